// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared opcode constants, bundle type codes, the instruction class enum and
//   helper functions used by the decode stage.
//   Instruction format: op = {instr[15:12], instr[7:4]}, fields instr[11:8] and instr[3:0].
package decode_pkg;

    // R-ALU / I-type operation nibbles
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1110;

    // Top-nibble groups and their sub-codes in instr[7:4]
    localparam logic [3:0] GRP_RALU  = 4'b0000;
    localparam logic [3:0] GRP_MEM   = 4'b0100;
    localparam logic [3:0] GRP_SHIFT = 4'b1000;
    localparam logic [3:0] GRP_LUI   = 4'b1111;
    localparam logic [3:0] SUB_LOAD  = 4'b0000;
    localparam logic [3:0] SUB_STORE = 4'b0100;
    localparam logic [3:0] SUB_LSH   = 4'b0100;
    localparam logic [3:0] SUB_ASHU  = 4'b0110;

    // Canonical ALU op codes emitted for the immediate shift and LUI
    localparam logic [7:0] ALU_OP_LSH = {GRP_SHIFT, SUB_LSH};
    localparam logic [7:0] ALU_OP_MOV = {4'b0000, OP_MOV};

    // Bundle type codes
    localparam logic [1:0] TYPE_ALU   = 2'b00;
    localparam logic [1:0] TYPE_STORE = 2'b01;
    localparam logic [1:0] TYPE_LOAD  = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_RALU,
        CLS_SHIFT,
        CLS_ITYPE,
        CLS_LSHI,
        CLS_LUI,
        CLS_LOAD,
        CLS_STORE
    } instr_class_e;

    // True for the eight nibbles shared by R-ALU and I-type encodings
    function automatic logic is_alu_code(input logic [3:0] code);
        return code inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV, OP_MUL};
    endfunction

    // Arithmetic immediates are sign-extended, logical ones and MOVI zero-extended
    function automatic logic imm_is_signed(input logic [3:0] code);
        return code inside {OP_ADD, OP_SUB, OP_CMP, OP_MUL};
    endfunction

    // Which decoded register fields the instruction reads: {reads_rdest, reads_rsrc}.
    // code is the operation nibble (instr[7:4] for R-ALU, instr[15:12] for I-type);
    // MOV/MOVI overwrite rdest without reading it. LOAD's address register sits in rsrc.
    function automatic logic [1:0] read_set(input instr_class_e cls, input logic [3:0] code);
        logic [1:0] rs;
        rs = 2'b00;
        case (cls)
            CLS_RALU:             rs = {code != OP_MOV, 1'b1};
            CLS_SHIFT, CLS_STORE: rs = 2'b11;
            CLS_ITYPE:            rs = {code != OP_MOV, 1'b0};
            CLS_LSHI:             rs = 2'b10;
            CLS_LOAD:             rs = 2'b01;
            default:              rs = 2'b00;
        endcase
        return rs;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// decode_logic
//   Purely combinational decoder: one 16-bit instruction in, decoded bundle
//   plus register read flags out. Registers and handshakes live in decode_stage.
// Ports
//   instr        in   16      raw instruction
//   alu_op       out  8       canonical ALU op code
//   rdest/rsrc   out  REG_AW  register indices (zero-extended nibbles)
//   imm          out  DATA_W  extended immediate
//   use_imm      out  1       ALU B operand is imm
//   itype        out  2       TYPE_ALU / TYPE_STORE / TYPE_LOAD
//   is_load      out  1       LOAD instruction
//   illegal      out  1       unrecognised encoding
//   reads_rdest  out  1       instruction reads the rdest field register
//   reads_rsrc   out  1       instruction reads the rsrc field register
module decode_logic #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic [15:0]       instr,
    output logic [7:0]        alu_op,
    output logic [REG_AW-1:0] rdest,
    output logic [REG_AW-1:0] rsrc,
    output logic [DATA_W-1:0] imm,
    output logic              use_imm,
    output logic [1:0]        itype,
    output logic              is_load,
    output logic              illegal,
    output logic              reads_rdest,
    output logic              reads_rsrc
);
    import decode_pkg::*;

    logic [3:0]   top;
    logic [3:0]   low;
    logic [3:0]   field_hi;
    logic [3:0]   field_lo;
    logic [3:0]   op_code;
    instr_class_e cls;

    assign top      = instr[15:12];
    assign field_hi = instr[11:8];
    assign low      = instr[7:4];
    assign field_lo = instr[3:0];

    // Classify the encoding. The group checks are ordered so that the fixed
    // top nibbles (shift, LUI, memory) win before the generic I-type match.
    always_comb begin
        cls = CLS_ILLEGAL;
        if (top == GRP_RALU && is_alu_code(low))
            cls = CLS_RALU;
        else if (top == GRP_SHIFT && (low == SUB_LSH || low == SUB_ASHU))
            cls = CLS_SHIFT;
        else if (top == GRP_SHIFT && low[3:1] == 3'b000)
            cls = CLS_LSHI;
        else if (top == GRP_LUI)
            cls = CLS_LUI;
        else if (top == GRP_MEM && low == SUB_LOAD)
            cls = CLS_LOAD;
        else if (top == GRP_MEM && low == SUB_STORE)
            cls = CLS_STORE;
        else if (is_alu_code(top))
            cls = CLS_ITYPE;
    end

    assign op_code = (cls == CLS_ITYPE) ? top : low;
    assign {reads_rdest, reads_rsrc} = read_set(cls, op_code);

    // Build the bundle fields. Everything defaults to zero so an illegal
    // instruction carries no operands, immediate or type information.
    always_comb begin
        alu_op  = 8'h00;
        rdest   = '0;
        rsrc    = '0;
        imm     = '0;
        use_imm = 1'b0;
        itype   = TYPE_ALU;
        is_load = 1'b0;
        illegal = 1'b0;
        case (cls)
            CLS_RALU: begin
                alu_op = {4'b0000, low};
                rdest  = REG_AW'(field_hi);
                rsrc   = REG_AW'(field_lo);
            end
            CLS_SHIFT: begin
                alu_op = {top, low};
                rdest  = REG_AW'(field_hi);
                rsrc   = REG_AW'(field_lo);
            end
            CLS_ITYPE: begin
                alu_op  = {4'b0000, top};
                rdest   = REG_AW'(field_hi);
                use_imm = 1'b1;
                imm     = imm_is_signed(top) ? DATA_W'($signed(instr[7:0]))
                                             : DATA_W'(instr[7:0]);
            end
            CLS_LSHI: begin
                alu_op  = ALU_OP_LSH;
                rdest   = REG_AW'(field_hi);
                use_imm = 1'b1;
                imm     = DATA_W'($signed(instr[4:0]));
            end
            CLS_LUI: begin
                alu_op  = ALU_OP_MOV;
                rdest   = REG_AW'(field_hi);
                use_imm = 1'b1;
                imm     = DATA_W'({instr[7:0], 8'h00});
            end
            CLS_LOAD: begin
                itype   = TYPE_LOAD;
                is_load = 1'b1;
                rsrc    = REG_AW'(field_hi);
                rdest   = REG_AW'(field_lo);
            end
            CLS_STORE: begin
                itype = TYPE_STORE;
                rsrc  = REG_AW'(field_hi);
                rdest = REG_AW'(field_lo);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered decode pipeline stage between fetch and register-read/ALU.
//   One instruction is accepted per valid/ready transfer; its decoded bundle
//   appears one cycle later and is held stable until downstream consumes it.
//   With HAZARD_EN=1 an instruction reading the destination of a held LOAD
//   waits, producing a single bubble.
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   flush               drop held bundle and incoming instruction
//   in_valid/in_ready   fetch-side handshake, in_instr raw instruction
//   out_valid/out_ready downstream handshake
//   out_alu_op, out_rdest, out_rsrc, out_imm, out_use_imm,
//   out_type, out_is_load, out_illegal   registered decoded bundle
module decode_stage #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 4,
    parameter int HAZARD_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_alu_op,
    output logic [REG_AW-1:0] out_rdest,
    output logic [REG_AW-1:0] out_rsrc,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_use_imm,
    output logic [1:0]        out_type,
    output logic              out_is_load,
    output logic              out_illegal
);
    import decode_pkg::*;

    logic [7:0]        dec_alu_op;
    logic [REG_AW-1:0] dec_rdest;
    logic [REG_AW-1:0] dec_rsrc;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_use_imm;
    logic [1:0]        dec_type;
    logic              dec_is_load;
    logic              dec_illegal;
    logic              dec_reads_rdest;
    logic              dec_reads_rsrc;
    logic              hazard;
    logic              accept;

    decode_logic #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .instr       (in_instr),
        .alu_op      (dec_alu_op),
        .rdest       (dec_rdest),
        .rsrc        (dec_rsrc),
        .imm         (dec_imm),
        .use_imm     (dec_use_imm),
        .itype       (dec_type),
        .is_load     (dec_is_load),
        .illegal     (dec_illegal),
        .reads_rdest (dec_reads_rdest),
        .reads_rsrc  (dec_reads_rsrc)
    );

    // Load-use check: the held LOAD's data is not available to the next
    // stage in time, so a consumer of its destination must wait one cycle.
    // Illegal instructions report no reads and therefore never stall here.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN != 0) begin
            hazard = out_valid && out_is_load && in_valid &&
                     ((dec_reads_rdest && dec_rdest == out_rdest) ||
                      (dec_reads_rsrc  && dec_rsrc  == out_rdest));
        end
    end

    assign in_ready = rst_n && !flush && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Output register: reset clears everything, flush only invalidates,
    // an accept loads a fresh bundle, and a lone consume empties the stage.
    // During a stall none of these fire, so every out_* bit holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_alu_op  <= 8'h00;
            out_rdest   <= '0;
            out_rsrc    <= '0;
            out_imm     <= '0;
            out_use_imm <= 1'b0;
            out_type    <= TYPE_ALU;
            out_is_load <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_alu_op  <= dec_alu_op;
            out_rdest   <= dec_rdest;
            out_rsrc    <= dec_rsrc;
            out_imm     <= dec_imm;
            out_use_imm <= dec_use_imm;
            out_type    <= dec_type;
            out_is_load <= dec_is_load;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
